// File: rtl/instruction_fetch.sv
// Fetch stage: issues a req/ack read for the current PC, holds the instruction for decode,
// pulses pcAdvance once per delivered instruction, and discards work on flush.
module instruction_fetch #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  flush,
   output logic                  memReq,
   output logic [ADDR_WIDTH-1:0] memAddress,
   input  logic                  memAck,
   input  logic [DATA_WIDTH-1:0] memData,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instrValid,
   input  logic                  instrReady,
   output logic                  pcAdvance,
   output logic                  fetchError
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      HOLD,
      DRAIN,
      ERROR
   } fetchState_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

   fetchState_t state;
   logic [7:0]  waitCount;
   logic [7:0]  nextCount;
   logic        timedOut;

   // The wait counter saturates, so the watchdog fires on the cycle the count would reach TIMEOUT.
   always_comb begin
      nextCount = (waitCount == 8'hFF) ? 8'hFF : waitCount + 8'd1;
      timedOut  = (nextCount >= TIMEOUT_LIMIT);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         memReq      <= 1'b0;
         memAddress  <= '0;
         instruction <= '0;
         instrValid  <= 1'b0;
         pcAdvance   <= 1'b0;
         fetchError  <= 1'b0;
         waitCount   <= 8'd0;
      end else begin
         pcAdvance <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!flush) begin
                  memAddress <= address;
                  memReq     <= 1'b1;
                  waitCount  <= 8'd0;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (memAck) begin
                  memReq <= 1'b0;
                  if (flush) begin
                     state <= IDLE;
                  end else begin
                     instruction <= memData;
                     instrValid  <= 1'b1;
                     pcAdvance   <= 1'b1;
                     state       <= HOLD;
                  end
               end else if (timedOut) begin
                  waitCount  <= nextCount;
                  memReq     <= 1'b0;
                  fetchError <= 1'b1;
                  state      <= ERROR;
               end else begin
                  waitCount <= nextCount;
                  if (flush) begin
                     state <= DRAIN;
                  end
               end
            end
            HOLD: begin
               if (flush || instrReady) begin
                  instrValid <= 1'b0;
                  state      <= IDLE;
               end
            end
            // The outstanding read must still complete before memory can take a new address.
            DRAIN: begin
               if (memAck) begin
                  memReq <= 1'b0;
                  state  <= IDLE;
               end else if (timedOut) begin
                  waitCount  <= nextCount;
                  memReq     <= 1'b0;
                  fetchError <= 1'b1;
                  state      <= ERROR;
               end else begin
                  waitCount <= nextCount;
               end
            end
            ERROR: begin
               memReq     <= 1'b0;
               instrValid <= 1'b0;
               fetchError <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: a PC model and a latency-programmable instruction memory
// surround the DUT; each task drives one scenario and checks against expected fetch behaviour.
module tb_instruction_fetch;

   localparam int AW = 20;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] address = '0;
   logic          flush = 1'b0;
   logic          memReq;
   logic [AW-1:0] memAddress;
   logic          memAck = 1'b0;
   logic [DW-1:0] memData = '0;
   logic [DW-1:0] instruction;
   logic          instrValid;
   logic          instrReady = 1'b0;
   logic          pcAdvance;
   logic          fetchError;

   int compared   = 0;
   int mismatched = 0;

   int memLatency    = 0;
   int reqCycles     = 0;
   bit memNeverAck   = 1'b0;
   bit randomLatency = 1'b0;

   always #5 clock = ~clock;

   instruction_fetch #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .address(address),
      .flush(flush),
      .memReq(memReq),
      .memAddress(memAddress),
      .memAck(memAck),
      .memData(memData),
      .instruction(instruction),
      .instrValid(instrValid),
      .instrReady(instrReady),
      .pcAdvance(pcAdvance),
      .fetchError(fetchError)
   );

   // Memory returns 0xA0000000 + address after memLatency un-acked request cycles.
   always @(posedge clock) begin
      #1;
      if (memReq) begin
         if (!memNeverAck && reqCycles == memLatency) begin
            memAck  = 1'b1;
            memData = 32'hA000_0000 + {12'h000, memAddress};
         end else begin
            memAck = 1'b0;
         end
         reqCycles++;
      end else begin
         memAck    = 1'b0;
         reqCycles = 0;
         if (randomLatency) memLatency = $urandom_range(0, 3);
      end
   end

   // PC model: increments at the end of any cycle in which pcAdvance is high.
   always @(negedge clock) begin
      if (pcAdvance) address = address + 20'd1;
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic doReset;
      reset         = 1'b0;
      flush         = 1'b0;
      instrReady    = 1'b0;
      memNeverAck   = 1'b0;
      randomLatency = 1'b0;
      memLatency    = 0;
      tick;
      tick;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      int n;
      reset = 1'b0;
      tick;
      tick;
      compared++;
      if ({memReq, instrValid, pcAdvance, fetchError, memAddress, instruction} !== 56'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got %h required 0",
                  {memReq, instrValid, pcAdvance, fetchError, memAddress, instruction});
      end
      memLatency = 20;
      address    = 20'h00123;
      reset      = 1'b1;
      n = 0;
      while (!memReq && n < 5) begin
         tick;
         n++;
      end
      compared++;
      if (memReq !== 1'b1 || memAddress !== 20'h00123) begin
         mismatched++;
         $display("[TB] FAIL reset_first_req: memReq=%b memAddress=%h required 1/00123", memReq, memAddress);
      end
      tick;
      reset = 1'b0;
      tick;
      tick;
      compared++;
      if ({memReq, instrValid, pcAdvance, fetchError, memAddress, instruction} !== 56'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_req: got %h required 0",
                  {memReq, instrValid, pcAdvance, fetchError, memAddress, instruction});
      end
      address = 20'h00055;
      reset   = 1'b1;
      tick;
      compared++;
      if (memReq !== 1'b1 || memAddress !== 20'h00055) begin
         mismatched++;
         $display("[TB] FAIL reset_refetch: memReq=%b memAddress=%h required 1/00055", memReq, memAddress);
      end
   endtask

   task automatic test_sequential;
      logic [DW-1:0] got[$];
      int            when[$];
      int            pulses;
      doReset;
      memLatency = 0;
      instrReady = 1'b1;
      address    = 20'h00000;
      pulses     = 0;
      for (int t = 1; t <= 9; t++) begin
         tick;
         if (pcAdvance) pulses++;
         if (instrValid) begin
            got.push_back(instruction);
            when.push_back(t);
         end
      end
      compared++;
      if (got.size() != 3) begin
         mismatched++;
         $display("[TB] FAIL seq_count: got %0d instructions required 3", got.size());
      end
      for (int i = 0; i < got.size() && i < 3; i++) begin
         compared++;
         if (got[i] !== 32'hA000_0000 + i || when[i] != 2 + 3 * i) begin
            mismatched++;
            $display("[TB] FAIL seq_instr%0d: got %h at cycle %0d required %h at cycle %0d",
                     i, got[i], when[i], 32'hA000_0000 + i, 2 + 3 * i);
         end
      end
      compared++;
      if (pulses != 3) begin
         mismatched++;
         $display("[TB] FAIL seq_pulses: got %0d required 3", pulses);
      end
      instrReady = 1'b0;
   endtask

   task automatic test_backpressure;
      doReset;
      memLatency = 0;
      address    = 20'h00010;
      tick;
      tick;
      compared++;
      if (instrValid !== 1'b1 || pcAdvance !== 1'b1 || instruction !== 32'hA000_0010) begin
         mismatched++;
         $display("[TB] FAIL bp_first_hold: valid=%b pcAdvance=%b instr=%h required 1/1/a0000010",
                  instrValid, pcAdvance, instruction);
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         compared++;
         if (instrValid !== 1'b1 || pcAdvance !== 1'b0 || memReq !== 1'b0 || instruction !== 32'hA000_0010) begin
            mismatched++;
            $display("[TB] FAIL bp_hold%0d: valid=%b pcAdvance=%b memReq=%b instr=%h required 1/0/0/a0000010",
                     i, instrValid, pcAdvance, memReq, instruction);
         end
      end
      instrReady = 1'b1;
      tick;
      instrReady = 1'b0;
      compared++;
      if (instrValid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp_release: valid=%b required 0", instrValid);
      end
      tick;
      compared++;
      if (memReq !== 1'b1 || memAddress !== 20'h00011) begin
         mismatched++;
         $display("[TB] FAIL bp_next_addr: memReq=%b memAddress=%h required 1/00011", memReq, memAddress);
      end
   endtask

   task automatic test_flush_wait;
      int  n;
      int  badPulses;
      bit  dropped;
      doReset;
      memLatency = 3;
      address    = 20'h00020;
      tick;
      tick;
      flush   = 1'b1;
      address = 20'h00400;
      tick;
      flush = 1'b0;
      compared++;
      if (memReq !== 1'b1 || instrValid !== 1'b0 || memAddress !== 20'h00020) begin
         mismatched++;
         $display("[TB] FAIL flush_drain: memReq=%b valid=%b memAddress=%h required 1/0/00020",
                  memReq, instrValid, memAddress);
      end
      n         = 0;
      badPulses = 0;
      dropped   = 1'b0;
      while (!(dropped && memReq) && n < 12) begin
         tick;
         n++;
         if (pcAdvance || instrValid) badPulses++;
         if (!memReq) dropped = 1'b1;
      end
      compared++;
      if (!(dropped && memReq) || memAddress !== 20'h00400) begin
         mismatched++;
         $display("[TB] FAIL flush_refetch: memReq=%b memAddress=%h required 1/00400", memReq, memAddress);
      end
      compared++;
      if (badPulses != 0) begin
         mismatched++;
         $display("[TB] FAIL flush_no_pulse: got %0d pulse/valid cycles required 0", badPulses);
      end
   endtask

   task automatic test_flush_hold;
      doReset;
      memLatency = 0;
      address    = 20'h00030;
      tick;
      tick;
      tick;
      flush      = 1'b1;
      instrReady = 1'b1;
      address    = 20'h00500;
      tick;
      instrReady = 1'b0;
      compared++;
      if (instrValid !== 1'b0 || memReq !== 1'b0 || pcAdvance !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL flushhold_drop: valid=%b memReq=%b pcAdvance=%b required 0/0/0",
                  instrValid, memReq, pcAdvance);
      end
      tick;
      flush = 1'b0;
      compared++;
      if (memReq !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL flushhold_idle_wait: memReq=%b required 0", memReq);
      end
      tick;
      compared++;
      if (memReq !== 1'b1 || memAddress !== 20'h00500) begin
         mismatched++;
         $display("[TB] FAIL flushhold_refetch: memReq=%b memAddress=%h required 1/00500", memReq, memAddress);
      end
      tick;
      compared++;
      if (instrValid !== 1'b1 || pcAdvance !== 1'b1 || instruction !== 32'hA000_0500) begin
         mismatched++;
         $display("[TB] FAIL flushhold_new_instr: valid=%b pcAdvance=%b instr=%h required 1/1/a0000500",
                  instrValid, pcAdvance, instruction);
      end
   endtask

   task automatic test_timeout;
      int n;
      doReset;
      memNeverAck = 1'b1;
      address     = 20'h00040;
      tick;
      n = 0;
      while (memReq && n < 20) begin
         n++;
         tick;
      end
      compared++;
      if (n != 8 || memReq !== 1'b0 || fetchError !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL timeout_fire: waited %0d memReq=%b fetchError=%b required 8/0/1",
                  n, memReq, fetchError);
      end
      for (int i = 0; i < 5; i++) begin
         flush      = i[0];
         instrReady = ~i[0];
         tick;
         compared++;
         if (fetchError !== 1'b1 || memReq !== 1'b0 || instrValid !== 1'b0 || pcAdvance !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL timeout_sticky%0d: fetchError=%b memReq=%b valid=%b pcAdvance=%b required 1/0/0/0",
                     i, fetchError, memReq, instrValid, pcAdvance);
         end
      end
      flush      = 1'b0;
      instrReady = 1'b0;
      reset      = 1'b0;
      tick;
      reset = 1'b1;
      compared++;
      if (fetchError !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL timeout_reset: fetchError=%b required 0", fetchError);
      end
      memNeverAck = 1'b0;
   endtask

   task automatic test_random_stream;
      logic [AW-1:0] start;
      logic [DW-1:0] prevInstr;
      int            accepted;
      int            pulses;
      bit            prevValid;
      bit            prevTaken;
      doReset;
      randomLatency = 1'b1;
      start         = 20'($urandom_range(0, 20'hFFF00));
      address       = start;
      accepted      = 0;
      pulses        = 0;
      prevValid     = 1'b0;
      prevTaken     = 1'b0;
      prevInstr     = '0;
      repeat (200) begin
         tick;
         instrReady = 1'($urandom_range(0, 1));
         if (pcAdvance) pulses++;
         if (instrValid && prevValid && !prevTaken) begin
            compared++;
            if (instruction !== prevInstr) begin
               mismatched++;
               $display("[TB] FAIL rand_stable: got %h required %h", instruction, prevInstr);
            end
         end
         if (instrValid && instrReady) begin
            compared++;
            if (instruction !== 32'hA000_0000 + {12'h000, start} + accepted) begin
               mismatched++;
               $display("[TB] FAIL rand_instr%0d: got %h required %h", accepted, instruction,
                        32'hA000_0000 + {12'h000, start} + accepted);
            end
            accepted++;
         end
         prevValid = instrValid;
         prevTaken = instrValid && instrReady;
         prevInstr = instruction;
      end
      compared++;
      if (accepted == 0 || pulses != accepted + int'(instrValid && !prevTaken) || fetchError !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rand_totals: accepted=%0d pulses=%0d fetchError=%b", accepted, pulses, fetchError);
      end
      randomLatency = 1'b0;
      instrReady    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset;
      test_sequential;
      test_backpressure;
      test_flush_wait;
      test_flush_hold;
      test_timeout;
      test_random_stream;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
